// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin 4:1 arbiter with registered valid/ready output
module mux4_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [3:0]       eff_req;
  logic             win_found;
  logic [1:0]       win_idx;
  logic             arb;
  logic [WIDTH-1:0] win_data;

  // A requester whose grant is pulsing right now is not eligible on this edge.
  assign eff_req = req & ~gnt_q;

  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + i[1:0];
      if (!win_found && eff_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    win_data = a;
    case (win_idx)
      2'd0: win_data = a;
      2'd1: win_data = b;
      2'd2: win_data = c;
      2'd3: win_data = d;
      default: win_data = a;
    endcase
  end

  // Arbitrate from IDLE, or back-to-back when the held word is being consumed.
  assign arb = win_found && ((state_q == IDLE) || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arb) state_d = SEND;
      SEND: if (out_ready && !arb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = 4'd0;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (arb) begin
      gnt_d   = 4'b0001 << win_idx;
      sel_d   = win_idx;
      data_d  = win_data;
      valid_d = 1'b1;
      ptr_d   = win_idx + 2'd1;
    end else if (state_q == SEND && out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a, b, c, d;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] dv [4];

  mux4_rr_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic v, input logic [3:0] dat);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".busy"}, 32'(busy), 32'(v));
    check({tag, ".data"}, 32'(out_data), 32'(dat));
  endtask

  task automatic expect_idle(input string tag, input logic [1:0] s);
    check({tag, ".gnt"}, 32'(gnt), 32'd0);
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    dv[0] = 4'b0100; dv[1] = 4'b1010; dv[2] = 4'b0011; dv[3] = 4'b1100;
    a = dv[0]; b = dv[1]; c = dv[2]; d = dv[3];
    rst_n = 1'b0; req = 4'd0; out_ready = 1'b0;
    #1;
    expect_out("rst", 4'd0, 2'd0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle with no requests
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("idle", 4'd0, 2'd0, 1'b0, 4'd0);
    end

    // full rotation a,b,c,d,a at one transfer per cycle
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (i % 4);
      step();
      expect_out($sformatf("rot%0d", i), eg, 2'(i % 4), 1'b1, dv[i % 4]);
      req = 4'b1111 & ~eg;
    end
    req = 4'd0;
    step();
    expect_idle("rot_end", 2'd0);

    // c alone, held by a stalled consumer
    req = 4'b0100; out_ready = 1'b0;
    step();
    expect_out("c_hold0", 4'b0100, 2'd2, 1'b1, dv[2]);
    req = 4'd0;
    for (int i = 1; i < 4; i++) begin
      step();
      expect_out($sformatf("c_hold%0d", i), 4'd0, 2'd2, 1'b1, dv[2]);
    end
    out_ready = 1'b1;
    step();
    expect_idle("c_acc", 2'd2);
    req = 4'b0100;
    step();
    expect_out("c_wrap", 4'b0100, 2'd2, 1'b1, dv[2]);
    req = 4'd0;
    step();
    expect_idle("c_wrap_end", 2'd2);

    // d wins, then pointer wraps to a, then b
    req = 4'b1000;
    step();
    expect_out("d_win", 4'b1000, 2'd3, 1'b1, dv[3]);
    req = 4'b0011;
    step();
    expect_out("wrap_a", 4'b0001, 2'd0, 1'b1, dv[0]);
    req = 4'b0010;
    step();
    expect_out("wrap_b", 4'b0010, 2'd1, 1'b1, dv[1]);
    req = 4'd0;
    step();
    expect_idle("wrap_end", 2'd1);

    // asynchronous reset while a word is held
    req = 4'b0100; out_ready = 1'b0;
    step();
    expect_out("pre_rst", 4'b0100, 2'd2, 1'b1, dv[2]);
    req = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'd0, 2'd0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0010; out_ready = 1'b1;
    step();
    expect_out("post_rst_b", 4'b0010, 2'd1, 1'b1, dv[1]);
    req = 4'd0;
    step();
    expect_idle("post_rst_end", 2'd1);

    // d/a held, consumer toggling ready
    req = 4'b1001; out_ready = 1'b1;
    step();
    expect_out("bb_d0", 4'b1000, 2'd3, 1'b1, dv[3]);
    step();
    expect_out("bb_a0", 4'b0001, 2'd0, 1'b1, dv[0]);
    out_ready = 1'b0;
    step();
    expect_out("bb_s0", 4'd0, 2'd0, 1'b1, dv[0]);
    out_ready = 1'b1;
    step();
    expect_out("bb_d1", 4'b1000, 2'd3, 1'b1, dv[3]);
    out_ready = 1'b0;
    step();
    expect_out("bb_s1", 4'd0, 2'd3, 1'b1, dv[3]);
    out_ready = 1'b1;
    step();
    expect_out("bb_a1", 4'b0001, 2'd0, 1'b1, dv[0]);
    req = 4'd0;
    step();
    expect_idle("bb_end", 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
